// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI4 bundle shared by the IFU, the LSU and the crossbar-facing port.
// Handshake rule on every channel: a beat transfers on the rising clk edge
// where valid and ready are both high; the source holds valid and payload
// stable until that edge, and ready may depend combinationally on valid.
interface axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 arbiter. One whole transaction
// (read or write, bursts included) owns the bus at a time; contention is
// resolved round-robin. Once granted, all channels of the owner are wired
// straight through, so there is no added latency inside a transaction.
module ysyx_24110015_axi_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  axi_if.slave       ifu,
  axi_if.slave       lsu,
  axi_if.master      axi_out,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;     // 0 = IFU, 1 = LSU
  logic   last;      // most recently granted master
  logic   grant_en;
  logic   grantee;
  logic   req_i, req_l;
  logic   active, sel_i, sel_l;

  logic [ADDR_W-1:0]   sel_araddr, sel_awaddr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;

  assign req_i  = ifu.arvalid | ifu.awvalid;
  assign req_l  = lsu.arvalid | lsu.awvalid;
  assign active = (state != IDLE);
  assign sel_i  = active & ~owner;
  assign sel_l  = active &  owner;
  assign state_dbg = state;

  // Next-state and grant decision; a master with both AR and AW pending goes read first.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    grantee   = owner;
    unique case (state)
      IDLE: begin
        if (req_i | req_l) begin
          grant_en  = 1'b1;
          grantee   = (req_i & req_l) ? ~last : req_l;
          state_nxt = (grantee ? lsu.arvalid : ifu.arvalid) ? RD : WR;
        end
      end
      RD: if (axi_out.rvalid & axi_out.rready & axi_out.rlast) state_nxt = IDLE;
      WR: if (axi_out.bvalid & axi_out.bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner and round-robin history; reset makes IFU win the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        owner <= grantee;
        last  <= grantee;
      end
    end
  end

  // Downstream payload follows the registered owner so it stays stable for the whole grant.
  assign sel_araddr = owner ? lsu.araddr : ifu.araddr;
  assign sel_awaddr = owner ? lsu.awaddr : ifu.awaddr;
  assign sel_wdata  = owner ? lsu.wdata  : ifu.wdata;
  assign sel_wstrb  = owner ? lsu.wstrb  : ifu.wstrb;

  assign axi_out.arid    = owner ? lsu.arid    : ifu.arid;
  assign axi_out.araddr  = sel_araddr;
  assign axi_out.arlen   = owner ? lsu.arlen   : ifu.arlen;
  assign axi_out.arsize  = owner ? lsu.arsize  : ifu.arsize;
  assign axi_out.arburst = owner ? lsu.arburst : ifu.arburst;
  assign axi_out.awid    = owner ? lsu.awid    : ifu.awid;
  assign axi_out.awaddr  = sel_awaddr;
  assign axi_out.awlen   = owner ? lsu.awlen   : ifu.awlen;
  assign axi_out.awsize  = owner ? lsu.awsize  : ifu.awsize;
  assign axi_out.awburst = owner ? lsu.awburst : ifu.awburst;
  assign axi_out.wdata   = sel_wdata;
  assign axi_out.wstrb   = sel_wstrb;
  assign axi_out.wlast   = owner ? lsu.wlast   : ifu.wlast;

  // Downstream handshake signals are only live while a transaction is granted.
  assign axi_out.arvalid = active & (owner ? lsu.arvalid : ifu.arvalid);
  assign axi_out.awvalid = active & (owner ? lsu.awvalid : ifu.awvalid);
  assign axi_out.wvalid  = active & (owner ? lsu.wvalid  : ifu.wvalid);
  assign axi_out.rready  = active & (owner ? lsu.rready  : ifu.rready);
  assign axi_out.bready  = active & (owner ? lsu.bready  : ifu.bready);

  // Upstream IFU side: only the owner sees readys and responses, others read zero.
  assign ifu.arready = sel_i & axi_out.arready;
  assign ifu.awready = sel_i & axi_out.awready;
  assign ifu.wready  = sel_i & axi_out.wready;
  assign ifu.rvalid  = sel_i & axi_out.rvalid;
  assign ifu.rid     = sel_i ? axi_out.rid   : '0;
  assign ifu.rdata   = sel_i ? axi_out.rdata : '0;
  assign ifu.rresp   = sel_i ? axi_out.rresp : '0;
  assign ifu.rlast   = sel_i & axi_out.rlast;
  assign ifu.bvalid  = sel_i & axi_out.bvalid;
  assign ifu.bid     = sel_i ? axi_out.bid   : '0;
  assign ifu.bresp   = sel_i ? axi_out.bresp : '0;

  // Upstream LSU side, mirror of the IFU gating.
  assign lsu.arready = sel_l & axi_out.arready;
  assign lsu.awready = sel_l & axi_out.awready;
  assign lsu.wready  = sel_l & axi_out.wready;
  assign lsu.rvalid  = sel_l & axi_out.rvalid;
  assign lsu.rid     = sel_l ? axi_out.rid   : '0;
  assign lsu.rdata   = sel_l ? axi_out.rdata : '0;
  assign lsu.rresp   = sel_l ? axi_out.rresp : '0;
  assign lsu.rlast   = sel_l & axi_out.rlast;
  assign lsu.bvalid  = sel_l & axi_out.bvalid;
  assign lsu.bid     = sel_l ? axi_out.bid   : '0;
  assign lsu.bresp   = sel_l ? axi_out.bresp : '0;

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter. The bench plays both upstream
// masters and the downstream slave by hand; inputs change 1 time unit after
// the rising edge, outputs are sampled on the falling edge.
module tb_ysyx_24110015_axi_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  axi_if #(.DATA_W(32), .ADDR_W(32)) ifu_bus ();
  axi_if #(.DATA_W(32), .ADDR_W(32)) lsu_bus ();
  axi_if #(.DATA_W(32), .ADDR_W(32)) out_bus ();

  ysyx_24110015_axi_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu       (ifu_bus),
    .lsu       (lsu_bus),
    .axi_out   (out_bus),
    .state_dbg (state_dbg)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_bus.arvalid = 0; ifu_bus.arid = 0; ifu_bus.araddr = 0; ifu_bus.arlen = 0;
    ifu_bus.arsize = 3'd2; ifu_bus.arburst = 2'b01; ifu_bus.rready = 1;
    ifu_bus.awvalid = 0; ifu_bus.awid = 0; ifu_bus.awaddr = 0; ifu_bus.awlen = 0;
    ifu_bus.awsize = 3'd2; ifu_bus.awburst = 2'b01; ifu_bus.wvalid = 0;
    ifu_bus.wdata = 0; ifu_bus.wstrb = 0; ifu_bus.wlast = 0; ifu_bus.bready = 1;
    lsu_bus.arvalid = 0; lsu_bus.arid = 0; lsu_bus.araddr = 0; lsu_bus.arlen = 0;
    lsu_bus.arsize = 3'd2; lsu_bus.arburst = 2'b01; lsu_bus.rready = 1;
    lsu_bus.awvalid = 0; lsu_bus.awid = 0; lsu_bus.awaddr = 0; lsu_bus.awlen = 0;
    lsu_bus.awsize = 3'd2; lsu_bus.awburst = 2'b01; lsu_bus.wvalid = 0;
    lsu_bus.wdata = 0; lsu_bus.wstrb = 0; lsu_bus.wlast = 0; lsu_bus.bready = 1;
    out_bus.arready = 1; out_bus.awready = 1; out_bus.wready = 1;
    out_bus.rvalid = 0; out_bus.rid = 0; out_bus.rdata = 0; out_bus.rresp = 0; out_bus.rlast = 0;
    out_bus.bvalid = 0; out_bus.bid = 0; out_bus.bresp = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    ifu_bus.arvalid = 1;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    checks++; if (out_bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_out_arvalid got=%b exp=0", out_bus.arvalid); end
    checks++; if (out_bus.rready !== 1'b0) begin errors++; $display("FAIL reset_out_rready got=%b exp=0", out_bus.rready); end
    checks++; if (ifu_bus.arready !== 1'b0) begin errors++; $display("FAIL reset_ifu_arready got=%b exp=0", ifu_bus.arready); end
    step();
    ifu_bus.arvalid = 0;
    rst = 0;
  endtask

  task automatic test_ifu_read();
    step();
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_0000; ifu_bus.arlen = 0; ifu_bus.arid = 4'h2;
    @(negedge clk);
    checks++; if (out_bus.arvalid !== 1'b0) begin errors++; $display("FAIL ifu_rd_idle_arvalid got=%b exp=0", out_bus.arvalid); end
    step();
    @(negedge clk);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL ifu_rd_state got=%0d exp=1", state_dbg); end
    checks++; if (out_bus.arvalid !== 1'b1) begin errors++; $display("FAIL ifu_rd_out_arvalid got=%b exp=1", out_bus.arvalid); end
    checks++; if (out_bus.araddr !== 32'h8000_0000) begin errors++; $display("FAIL ifu_rd_araddr got=%h exp=80000000", out_bus.araddr); end
    checks++; if (out_bus.arid !== 4'h2) begin errors++; $display("FAIL ifu_rd_arid got=%h exp=2", out_bus.arid); end
    checks++; if (ifu_bus.arready !== 1'b1) begin errors++; $display("FAIL ifu_rd_arready got=%b exp=1", ifu_bus.arready); end
    checks++; if (lsu_bus.arready !== 1'b0) begin errors++; $display("FAIL ifu_rd_lsu_arready got=%b exp=0", lsu_bus.arready); end
    step();
    ifu_bus.arvalid = 0;
    step();
    step();
    out_bus.rvalid = 1; out_bus.rdata = 32'h0000_0413; out_bus.rlast = 1; out_bus.rid = 4'h2;
    @(negedge clk);
    checks++; if (ifu_bus.rvalid !== 1'b1) begin errors++; $display("FAIL ifu_rd_rvalid got=%b exp=1", ifu_bus.rvalid); end
    checks++; if (ifu_bus.rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rd_rdata got=%h exp=00000413", ifu_bus.rdata); end
    checks++; if (lsu_bus.rvalid !== 1'b0) begin errors++; $display("FAIL ifu_rd_lsu_rvalid got=%b exp=0", lsu_bus.rvalid); end
    checks++; if (lsu_bus.rdata !== 32'h0) begin errors++; $display("FAIL ifu_rd_lsu_rdata got=%h exp=0", lsu_bus.rdata); end
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0; out_bus.rdata = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ifu_rd_done_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_lsu_write();
    step();
    lsu_bus.awvalid = 1; lsu_bus.awaddr = 32'h0200_4000; lsu_bus.awid = 4'h3; lsu_bus.awlen = 0;
    lsu_bus.wvalid = 1; lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wstrb = 4'hF; lsu_bus.wlast = 1;
    step();
    @(negedge clk);
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL lsu_wr_state got=%0d exp=2", state_dbg); end
    checks++; if (out_bus.awvalid !== 1'b1) begin errors++; $display("FAIL lsu_wr_awvalid got=%b exp=1", out_bus.awvalid); end
    checks++; if (out_bus.awaddr !== 32'h0200_4000) begin errors++; $display("FAIL lsu_wr_awaddr got=%h exp=02004000", out_bus.awaddr); end
    checks++; if (out_bus.awid !== 4'h3) begin errors++; $display("FAIL lsu_wr_awid got=%h exp=3", out_bus.awid); end
    checks++; if (out_bus.wvalid !== 1'b1) begin errors++; $display("FAIL lsu_wr_wvalid got=%b exp=1", out_bus.wvalid); end
    checks++; if (out_bus.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lsu_wr_wdata got=%h exp=deadbeef", out_bus.wdata); end
    checks++; if (out_bus.wstrb !== 4'hF) begin errors++; $display("FAIL lsu_wr_wstrb got=%h exp=f", out_bus.wstrb); end
    checks++; if (out_bus.wlast !== 1'b1) begin errors++; $display("FAIL lsu_wr_wlast got=%b exp=1", out_bus.wlast); end
    checks++; if (lsu_bus.awready !== 1'b1) begin errors++; $display("FAIL lsu_wr_awready got=%b exp=1", lsu_bus.awready); end
    checks++; if (ifu_bus.awready !== 1'b0) begin errors++; $display("FAIL lsu_wr_ifu_awready got=%b exp=0", ifu_bus.awready); end
    step();
    lsu_bus.awvalid = 0; lsu_bus.wvalid = 0;
    out_bus.bvalid = 1; out_bus.bresp = 2'b00; out_bus.bid = 4'h3;
    @(negedge clk);
    checks++; if (lsu_bus.bvalid !== 1'b1) begin errors++; $display("FAIL lsu_wr_bvalid got=%b exp=1", lsu_bus.bvalid); end
    checks++; if (lsu_bus.bresp !== 2'b00) begin errors++; $display("FAIL lsu_wr_bresp got=%b exp=00", lsu_bus.bresp); end
    checks++; if (lsu_bus.bid !== 4'h3) begin errors++; $display("FAIL lsu_wr_bid got=%h exp=3", lsu_bus.bid); end
    checks++; if (ifu_bus.bvalid !== 1'b0) begin errors++; $display("FAIL lsu_wr_ifu_bvalid got=%b exp=0", ifu_bus.bvalid); end
    step();
    out_bus.bvalid = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL lsu_wr_done_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_contention();
    #1 rst = 1;
    step();
    rst = 0;
    clear_inputs();
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_0100;
    lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h8000_0200;
    step();
    @(negedge clk);
    checks++; if (out_bus.araddr !== 32'h8000_0100) begin errors++; $display("FAIL cont1_araddr got=%h exp=80000100", out_bus.araddr); end
    checks++; if (lsu_bus.arready !== 1'b0) begin errors++; $display("FAIL cont1_lsu_arready got=%b exp=0", lsu_bus.arready); end
    step();
    ifu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1; out_bus.rdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (ifu_bus.rdata !== 32'h1111_1111) begin errors++; $display("FAIL cont1_ifu_rdata got=%h exp=11111111", ifu_bus.rdata); end
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL cont_bubble_state got=%0d exp=0", state_dbg); end
    checks++; if (out_bus.arvalid !== 1'b0) begin errors++; $display("FAIL cont_bubble_arvalid got=%b exp=0", out_bus.arvalid); end
    step();
    @(negedge clk);
    checks++; if (out_bus.araddr !== 32'h8000_0200) begin errors++; $display("FAIL cont2_araddr got=%h exp=80000200", out_bus.araddr); end
    checks++; if (lsu_bus.arready !== 1'b1) begin errors++; $display("FAIL cont2_lsu_arready got=%b exp=1", lsu_bus.arready); end
    step();
    lsu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1; out_bus.rdata = 32'h2222_2222;
    @(negedge clk);
    checks++; if (lsu_bus.rdata !== 32'h2222_2222) begin errors++; $display("FAIL cont2_lsu_rdata got=%h exp=22222222", lsu_bus.rdata); end
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_0300;
    lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h8000_0400;
    step();
    @(negedge clk);
    checks++; if (out_bus.araddr !== 32'h8000_0300) begin errors++; $display("FAIL cont3_araddr got=%h exp=80000300", out_bus.araddr); end
    step();
    ifu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1;
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    step();
    @(negedge clk);
    checks++; if (out_bus.araddr !== 32'h8000_0400) begin errors++; $display("FAIL cont4_araddr got=%h exp=80000400", out_bus.araddr); end
    step();
    lsu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1;
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
  endtask

  task automatic test_burst();
    step();
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_1000; ifu_bus.arlen = 8'd3;
    step();
    @(negedge clk);
    checks++; if (out_bus.arlen !== 8'd3) begin errors++; $display("FAIL burst_arlen got=%0d exp=3", out_bus.arlen); end
    step();
    ifu_bus.arvalid = 0;
    for (int beat = 0; beat < 4; beat++) begin
      out_bus.rvalid = 1;
      out_bus.rdata = 32'h100 + beat;
      out_bus.rlast = (beat == 3);
      out_bus.rresp = (beat == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++; if (ifu_bus.rdata !== 32'h100 + beat) begin errors++; $display("FAIL burst_rdata beat=%0d got=%h exp=%h", beat, ifu_bus.rdata, 32'h100 + beat); end
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL burst_state beat=%0d got=%0d exp=1", beat, state_dbg); end
      if (beat == 1) begin
        checks++; if (ifu_bus.rresp !== 2'b10) begin errors++; $display("FAIL burst_rresp got=%b exp=10", ifu_bus.rresp); end
      end
      if (beat >= 2) begin
        checks++; if (lsu_bus.arready !== 1'b0) begin errors++; $display("FAIL burst_lsu_held beat=%0d got=%b exp=0", beat, lsu_bus.arready); end
      end
      step();
      if (beat == 0) begin
        lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h0000_3000;
      end
    end
    out_bus.rvalid = 0; out_bus.rlast = 0; out_bus.rresp = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL burst_done_state got=%0d exp=0", state_dbg); end
    checks++; if (lsu_bus.arready !== 1'b0) begin errors++; $display("FAIL burst_bubble_lsu_arready got=%b exp=0", lsu_bus.arready); end
    step();
    @(negedge clk);
    checks++; if (out_bus.araddr !== 32'h0000_3000) begin errors++; $display("FAIL burst_lsu_araddr got=%h exp=00003000", out_bus.araddr); end
    checks++; if (lsu_bus.arready !== 1'b1) begin errors++; $display("FAIL burst_lsu_arready got=%b exp=1", lsu_bus.arready); end
    step();
    lsu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1;
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
  endtask

  task automatic test_read_then_write();
    step();
    lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h0200_0000; lsu_bus.arlen = 0;
    lsu_bus.awvalid = 1; lsu_bus.awaddr = 32'h0200_0008;
    lsu_bus.wvalid = 1; lsu_bus.wdata = 32'h1234_5678; lsu_bus.wstrb = 4'hF; lsu_bus.wlast = 1;
    out_bus.awready = 0; out_bus.wready = 0;
    step();
    @(negedge clk);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL rw_first_state got=%0d exp=1", state_dbg); end
    checks++; if (lsu_bus.awready !== 1'b0) begin errors++; $display("FAIL rw_awready_during_rd got=%b exp=0", lsu_bus.awready); end
    step();
    lsu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1; out_bus.rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (lsu_bus.rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rw_rdata got=%h exp=cafef00d", lsu_bus.rdata); end
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rw_bubble_state got=%0d exp=0", state_dbg); end
    step();
    out_bus.awready = 1; out_bus.wready = 1;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL rw_wr_state got=%0d exp=2", state_dbg); end
    checks++; if (out_bus.awaddr !== 32'h0200_0008) begin errors++; $display("FAIL rw_awaddr got=%h exp=02000008", out_bus.awaddr); end
    checks++; if (lsu_bus.wready !== 1'b1) begin errors++; $display("FAIL rw_wready got=%b exp=1", lsu_bus.wready); end
    step();
    lsu_bus.awvalid = 0; lsu_bus.wvalid = 0;
    out_bus.bvalid = 1;
    @(negedge clk);
    checks++; if (lsu_bus.bvalid !== 1'b1) begin errors++; $display("FAIL rw_bvalid got=%b exp=1", lsu_bus.bvalid); end
    step();
    out_bus.bvalid = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rw_done_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_reset_mid();
    step();
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_2000; ifu_bus.arlen = 0;
    step();
    step();
    ifu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1; out_bus.rdata = 32'h0000_0055;
    @(negedge clk);
    checks++; if (ifu_bus.rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rvalid got=%b exp=1", ifu_bus.rvalid); end
    #1 rst = 1;
    #1;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", state_dbg); end
    checks++; if (ifu_bus.rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_ifu_rvalid got=%b exp=0", ifu_bus.rvalid); end
    checks++; if (ifu_bus.rdata !== 32'h0) begin errors++; $display("FAIL rstmid_ifu_rdata got=%h exp=0", ifu_bus.rdata); end
    checks++; if (out_bus.rready !== 1'b0) begin errors++; $display("FAIL rstmid_out_rready got=%b exp=0", out_bus.rready); end
    out_bus.rvalid = 0; out_bus.rlast = 0;
    step();
    rst = 0;
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_3000;
    step();
    @(negedge clk);
    checks++; if (out_bus.araddr !== 32'h8000_3000) begin errors++; $display("FAIL rstmid_new_araddr got=%h exp=80003000", out_bus.araddr); end
    step();
    ifu_bus.arvalid = 0;
    out_bus.rvalid = 1; out_bus.rlast = 1; out_bus.rdata = 32'h0000_0077;
    @(negedge clk);
    checks++; if (ifu_bus.rdata !== 32'h0000_0077) begin errors++; $display("FAIL rstmid_new_rdata got=%h exp=00000077", ifu_bus.rdata); end
    step();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rstmid_new_done got=%0d exp=0", state_dbg); end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_contention();
    test_burst();
    test_read_then_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_axi_arbiter.md
# ysyx_24110015_axi_arbiter

Two-master to one-slave AXI4 arbiter. It merges the IFU and LSU AXI master ports onto the single AXI master port that feeds the address crossbar, which fans out to CLINT/SoC. It grants the bus to one whole transaction at a time (read or write, including bursts), using round-robin priority under contention.

## Interface
- Parameters:
  - DATA_W, default 32: data width of rdata/wdata. wstrb is DATA_W/8 bits.
  - ADDR_W, default 32: width of araddr/awaddr.
- Ports:
  - clk  input  1  clock.
  - rst  input  1  reset; asynchronous, active-high.
  - ifu  axi_if.slave  interface  instruction-fetch master (read-only in practice; write channels still honoured).
  - lsu  axi_if.slave  interface  load/store master.
  - axi_out  axi_if.master  interface  merged downstream port to the crossbar.

## Operation
- State: state ∈ {IDLE, RD, WR}, 2-bit encoded.
- Registers:
  - owner: 0 = IFU, 1 = LSU.
  - last: master granted most recently.
- Reset values: state=IDLE, owner=0, last=1 (LSU), so the first contention goes to IFU.
- Request of master m: req_m = m.arvalid | m.awvalid.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one master requests, grant it.
  - If both request, grant ~last.
  - On a grant: owner <= grantee and last <= grantee.
  - Next state is RD if grantee.arvalid, else WR. A master asserting both arvalid and awvalid is served read first.
- RD / WR: the owner's AR, AW, W, R and B channels are connected straight through to axi_out, with valid/ready in both directions and all payload fields (id, addr, len, size, burst, data, strb, last, resp).
- RD completes on the cycle axi_out.rvalid & rready & rlast are all high. Next state is IDLE.
- WR completes on the cycle axi_out.bvalid & bready are both high. Next state is IDLE.
- Non-owner master, in every state: arready, awready, wready, rvalid, bvalid are 0; rdata, rresp, bresp, rlast are 0.
- IDLE drives everything inactive:
  - Downstream valids/readys (arvalid, awvalid, wvalid, rready, bready) are 0.
  - Upstream readys/valids are 0 for both masters.
- Downstream payload fields are always muxed from owner, so they are stable through the grant.
- Response passthrough is transparent: rresp/bresp errors are forwarded unchanged, and the arbiter does not retry.
- Reset mid-transaction: state returns to IDLE immediately (asynchronously) and all outputs go inactive. The in-flight transaction is abandoned; downstream is reset by the same rst.

## Timing
- Grant latency: a request first seen in IDLE at cycle N gives state=RD/WR at N+1. axi_out.arvalid (or awvalid) is first driven at N+1.
- Completion at cycle M gives IDLE at M+1. The next grant decision is made at M+1 and forwarding resumes at M+2, a one-cycle bubble between transactions.
- Inside RD/WR there is no added latency: pure combinational forwarding, and handshakes complete in the same cycle as the downstream slave.
- Masters must hold arvalid/awvalid and payload stable until their ready. A losing master simply waits with valid high.
- Bursts: all arlen+1 read beats are forwarded and the grant is held until the rlast beat. Write bursts are held until the B handshake.
- No combinational path from a master's valid to the other master's ready.

## Test plan
- Single IFU read, araddr=0x8000_0000, arlen=0, slave returns rdata=0x0000_0413 after 2 cycles:
  - ifu.rvalid with that data.
  - lsu sees no activity.
  - state back to IDLE the cycle after rlast.
- Single LSU write, awaddr=0x0200_4000, wdata=0xDEAD_BEEF, wstrb=0xF:
  - axi_out carries the exact AW/W fields.
  - lsu.bvalid is asserted with bresp=0.
  - ifu.bvalid stays 0.
- Both masters issue a read in the same IDLE cycle right after reset:
  - IFU is granted first.
  - LSU is granted at completion+1.
  - The next simultaneous request is granted to IFU again (alternation).
- IFU burst read with arlen=3:
  - Grant is held across 4 beats.
  - An LSU request arriving after beat 1 is served only after the beat with rlast=1.
- LSU asserts arvalid and awvalid together:
  - The read transaction completes first.
  - The write follows after one IDLE cycle.
- rst pulsed while in RD with rvalid pending:
  - All outputs go to 0 immediately (asynchronously).
  - After rst deasserts, a fresh IFU read completes normally.
